store_buffer: RTL

Posted-write buffer between the single-cycle core's data-memory port and a slower handshaked data memory. Core stores are accepted in one cycle into a FIFO and drained to memory over a req/ack handshake. Core loads read memory combinationally, with the youngest matching buffered store forwarded. A stall is raised only when a store arrives with the buffer full.

---
 rtl/store_buffer.sv | 112 +++++++++++
 1 files changed

// File: rtl/store_buffer.sv
// store_buffer: posted-write FIFO between the core data port and a handshaked data memory
// Ports:
//   clk, reset (async, active-low)
//   core_we/core_addr/core_wd   core store strobe, byte address and store data
//   core_rd, core_stall         load data (forwarded or memory) and store-full stall, combinational
//   mem_raddr/mem_rdata         combinational memory read path, mem_raddr mirrors core_addr
//   mem_req/mem_addr/mem_wd     head write request, held stable until mem_ack
//   mem_ack                     memory accepted the head write this cycle
//   sb_empty/sb_full            registered occupancy flags
// Build option: define SB_COALESCE_EN to merge a store into the youngest entry on a word-address hit.
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          core_we,
    input  logic [AW-1:0] core_addr,
    input  logic [DW-1:0] core_wd,
    output logic [DW-1:0] core_rd,
    output logic          core_stall,
    output logic [AW-1:0] mem_raddr,
    input  logic [DW-1:0] mem_rdata,
    output logic          mem_req,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wd,
    input  logic          mem_ack,
    output logic          sb_empty,
    output logic          sb_full
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int WW = AW - 2;

    logic [WW-1:0]    addr_q [DEPTH];
    logic [DW-1:0]    data_q [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [PW-1:0]    head, tail;
    logic [PW-1:0]    ring [DEPTH];
    logic [CW-1:0]    count, count_n;
    logic             empty_q, full_q;
    logic [WW-1:0]    word;
    logic             push, pop, coal;
    logic             unused_lsb;

    assign word       = core_addr[AW-1:2];
    assign unused_lsb = ^core_addr[1:0];

`ifdef SB_COALESCE_EN
    logic [PW-1:0] last;
    assign last = tail - PW'(1);
    // The head entry cannot be rewritten while memory may be latching it.
    assign coal = core_we & valid_q[last] & (addr_q[last] == word) & ~((last == head) & mem_req);
`else
    assign coal = 1'b0;
`endif

    assign mem_req    = ~empty_q;
    assign pop        = mem_req & mem_ack;
    assign core_stall = core_we & full_q & ~coal;
    assign push       = core_we & ~full_q & ~coal;
    assign count_n    = count + CW'(push) - CW'(pop);
    assign mem_raddr  = core_addr;
    assign mem_addr   = {addr_q[head], 2'b00};
    assign mem_wd     = data_q[head];
    assign sb_empty   = empty_q;
    assign sb_full    = full_q;

    // ring[g] is the slot g positions younger than the head.
    for (genvar g = 0; g < DEPTH; g++) begin : g_ring
        assign ring[g] = head + PW'(g);
    end

    // Scan oldest to youngest so the youngest hit wins.
    always_comb begin
        core_rd = mem_rdata;
        for (int i = 0; i < DEPTH; i++)
            core_rd = (valid_q[ring[i]] && addr_q[ring[i]] == word) ? data_q[ring[i]] : core_rd;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
            valid_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else begin
            if (push) begin
                addr_q[tail] <= word;
                data_q[tail] <= core_wd;
                tail         <= tail + PW'(1);
            end
`ifdef SB_COALESCE_EN
            if (coal)
                data_q[last] <= core_wd;
`endif
            if (pop)
                head <= head + PW'(1);
            valid_q <= (valid_q & ~(DEPTH'(pop) << head)) | (DEPTH'(push) << tail);
            count   <= count_n;
            empty_q <= count_n == '0;
            full_q  <= count_n == CW'(DEPTH);
        end
    end
endmodule
